// File: rtl/jsv_fb_pkg.sv
// Shared framebuffer definitions for the fractal writer and the line reader.
package jsv_fb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    NEXT = 2'd2
  } fb_state_t;

  localparam logic [3:0] FB_BYTE_EN = 4'b0011;

  function automatic int fb_width(input int h_pix, input int scale);
    return h_pix / scale;
  endfunction

  function automatic int fb_height(input int v_pix, input int scale);
    return v_pix / scale;
  endfunction

endpackage

// File: rtl/fb_line_ram.sv
// Ping-pong line buffer: simple dual-port RAM, one write port, registered read port.
module fb_line_ram #(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fb_line_reader.sv
// Fetches framebuffer rows one row ahead of the raster into a ping-pong line
// buffer and presents the iteration value for the current DrawX/DrawY.
module fb_line_reader
  import jsv_fb_pkg::*;
#(
  parameter int H_PIX     = 640,
  parameter int V_PIX     = 480,
  parameter int SCALE     = 2,
  parameter int ADDR_W    = 19,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  output logic [ADDR_W-1:0] bridge_address,
  output logic              bridge_read,
  output logic [3:0]        bridge_byte_enable,
  input  logic              bridge_acknowledge,
  input  logic [15:0]       bridge_read_data,
  output logic [7:0]        PIX_I,
  output logic              PIX_VALID,
  output logic              FETCH_BUSY,
  output logic              UNDERRUN
);

  localparam int FW   = fb_width(H_PIX, SCALE);
  localparam int FH   = fb_height(V_PIX, SCALE);
  localparam int RA_W = $clog2(2 * FW);

  fb_state_t         state_q, state_d;
  logic [7:0]        row_q, row_d;
  logic [7:0]        pend_row_q, pend_row_d;
  logic              pend_q, pend_d;
  logic [8:0]        col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              und_q, und_d;
  logic              pix_valid_q;
  logic [9:0]        dy_prev_q;

  logic              trig;
  logic [7:0]        trig_row;
  logic [9:0]        dy_div, dy_mod, dx_div;
  logic [8:0]        rd_col;
  logic              we;
  logic [RA_W-1:0]   waddr, raddr;
  logic [7:0]        ram_q;
  logic              unused_hi;

  assign unused_hi = ^bridge_read_data[15:8];

  // Row k+1 is fetched while row k is on screen; the frame's row 0 during vblank.
  always_comb begin
    dy_div   = DrawY / 10'(SCALE);
    dy_mod   = DrawY % 10'(SCALE);
    trig     = 1'b0;
    trig_row = 8'd0;
    if (DrawY != dy_prev_q) begin
      if (DrawY == 10'(V_PIX)) begin
        trig = 1'b1;
      end else if (dy_mod == 10'd0 && dy_div < 10'(FH - 1)) begin
        trig     = 1'b1;
        trig_row = 8'(dy_div + 10'd1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pend_d     = pend_q;
    pend_row_d = pend_row_q;
    und_d      = und_q;
    we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          row_d   = trig_row;
          col_d   = 9'd0;
          state_d = READ;
        end
      end
      READ: begin
        if (trig) begin
          und_d      = 1'b1;
          pend_d     = 1'b1;
          pend_row_d = trig_row;
        end
        if (bridge_acknowledge) begin
          we = 1'b1;
          // A late trigger abandons the old row once the bus transaction ends.
          if (trig || pend_q) begin
            row_d   = trig ? trig_row : pend_row_q;
            col_d   = 9'd0;
            pend_d  = 1'b0;
            state_d = READ;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        if (trig) begin
          und_d   = 1'b1;
          row_d   = trig_row;
          col_d   = 9'd0;
          state_d = READ;
        end else if (col_q == 9'(FW - 1)) begin
          state_d = IDLE;
        end else begin
          col_d   = col_q + 9'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
    addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(row_d) * ADDR_W'(FW) + ADDR_W'(col_d);
    rd_d   = (state_d == READ);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      row_q       <= 8'd0;
      col_q       <= 9'd0;
      pend_q      <= 1'b0;
      pend_row_q  <= 8'd0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      und_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      dy_prev_q   <= DrawY;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pend_q      <= pend_d;
      pend_row_q  <= pend_row_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      und_q       <= und_d;
      pix_valid_q <= blank;
      dy_prev_q   <= DrawY;
    end
  end

  // Columns past the visible width are clamped so the read stays inside the buffer.
  always_comb begin
    dx_div = DrawX / 10'(SCALE);
    rd_col = (dx_div >= 10'(FW)) ? 9'(FW - 1) : dx_div[8:0];
    raddr  = ({RA_W{dy_div[0]}} & RA_W'(FW)) + RA_W'(rd_col);
    waddr  = ({RA_W{row_q[0]}} & RA_W'(FW)) + RA_W'(col_q);
  end

  fb_line_ram #(
    .DEPTH (2 * FW),
    .AW    (RA_W)
  ) u_line_ram (
    .clk   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (bridge_read_data[7:0]),
    .raddr (raddr),
    .rdata (ram_q)
  );

  assign bridge_address     = addr_q;
  assign bridge_read        = rd_q;
  assign bridge_byte_enable = FB_BYTE_EN;
  assign FETCH_BUSY         = (state_q != IDLE);
  assign UNDERRUN           = und_q;
  assign PIX_VALID          = pix_valid_q;
  assign PIX_I              = pix_valid_q ? ram_q : 8'd0;

endmodule

// File: tb/tb_fb_line_reader.sv
// Bench for fb_line_reader: SDRAM/bridge responder, pixel vector table, fetch sequences.
module tb_fb_line_reader;

  localparam int FW = 320;

  logic        clk;
  logic        rst_n;
  logic [9:0]  draw_x, draw_y;
  logic        blank;
  logic [18:0] br_addr;
  logic        br_read;
  logic [3:0]  br_be;
  logic        br_ack;
  logic [15:0] br_data;
  logic [7:0]  pix_i;
  logic        pix_valid, fetch_busy, underrun;

  int checks = 0;
  int errors = 0;

  int          ack_waits = 1;
  bit          hold      = 0;
  bit          len_check = 1;
  logic [7:0]  salt      = 8'h00;
  int unsigned rd_addrs[$];
  int          stab_err  = 0;
  int          len_bad   = 0;
  int          wait_cnt  = 0;
  int          cur_len   = 0;
  logic [18:0] prev_addr = '0;
  bit          prev_pend = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    bit         b;
    logic [7:0] exp_pix;
    bit         exp_v;
  } vec_t;
  vec_t tbl[16];

  fb_line_reader dut (
    .CLK                (clk),
    .RESET              (rst_n),
    .DrawX              (draw_x),
    .DrawY              (draw_y),
    .blank              (blank),
    .bridge_address     (br_addr),
    .bridge_read        (br_read),
    .bridge_byte_enable (br_be),
    .bridge_acknowledge (br_ack),
    .bridge_read_data   (br_data),
    .PIX_I              (pix_i),
    .PIX_VALID          (pix_valid),
    .FETCH_BUSY         (fetch_busy),
    .UNDERRUN           (underrun)
  );

  initial begin
    clk = 0;
    forever #10 clk = ~clk;
  end

  // SDRAM content as seen through the bridge: low byte of the word address, salted.
  function automatic logic [7:0] data_of(input int unsigned a, input logic [7:0] s);
    return 8'(a) ^ s;
  endfunction

  // Framebuffer pixel shown at screen (x,y), given the salt of the fetch that filled it.
  function automatic logic [7:0] fb_pix(input int x, input int y, input logic [7:0] s);
    return data_of((y / 2) * FW + x / 2, s);
  endfunction

  // Bridge model: acks after ack_waits extra cycles, logs transactions, checks stability.
  initial begin
    br_ack  = 0;
    br_data = '0;
    forever begin
      @(negedge clk);
      br_ack  = 0;
      br_data = 16'($urandom);
      if (br_read) begin
        if (prev_pend && br_addr != prev_addr) stab_err++;
        cur_len++;
        if (!hold && wait_cnt >= ack_waits) begin
          br_ack  = 1;
          br_data = {8'($urandom), data_of(br_addr, salt)};
          rd_addrs.push_back(br_addr);
          if (len_check && cur_len != ack_waits + 1) len_bad++;
          wait_cnt  = 0;
          cur_len   = 0;
          prev_pend = 0;
        end else begin
          wait_cnt++;
          prev_pend = 1;
        end
        prev_addr = br_addr;
      end else begin
        wait_cnt  = 0;
        cur_len   = 0;
        prev_pend = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (fetch_busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " fetch done within budget"}, int'(fetch_busy), 0);
  endtask

  task automatic check_reads(input string name, input int unsigned base, input int n);
    int bad = 0;
    chk({name, " read count"}, rd_addrs.size(), n);
    for (int i = 0; i < n && i < rd_addrs.size(); i++)
      if (rd_addrs[i] != base + i) bad++;
    chk({name, " read addresses wrong"}, bad, 0);
    rd_addrs.delete();
  endtask

  task automatic pix(input string name, input int x, input int y, input bit b,
                     input int exp_pix, input int exp_v);
    draw_x = 10'(x);
    draw_y = 10'(y);
    blank  = b;
    @(negedge clk);
    chk({name, " PIX_I"}, int'(pix_i), exp_pix);
    chk({name, " PIX_VALID"}, int'(pix_valid), exp_v);
  endtask

  initial begin
    int x;
    rst_n  = 0;
    draw_x = 0;
    draw_y = 0;
    blank  = 0;

    // Reset with DrawY moving between trigger lines
    for (int i = 0; i < 3; i++) begin
      draw_y = (i % 2 == 0) ? 10'd2 : 10'd0;
      tick(1);
    end
    draw_y = 10'd2;
    tick(1);
    chk("reset bridge_read", int'(br_read), 0);
    chk("reset PIX_I", int'(pix_i), 0);
    chk("reset UNDERRUN", int'(underrun), 0);
    chk("reset FETCH_BUSY", int'(fetch_busy), 0);
    chk("reset PIX_VALID", int'(pix_valid), 0);
    chk("byte enable", int'(br_be), 3);
    rst_n = 1;
    tick(6);
    chk("no fetch after reset", int'(fetch_busy), 0);
    chk("no read after reset", rd_addrs.size(), 0);

    // Frame prefetch: row 0 into bank 0
    draw_y = 10'd479;
    tick(2);
    draw_y = 10'd480;
    wait_idle("row0");
    check_reads("row0", 0, 320);
    chk("row0 handshake stable", stab_err, 0);
    chk("row0 handshake length", len_bad, 0);
    chk("row0 no underrun", int'(underrun), 0);

    // DrawY=0 shows row 0 and starts row 1
    pix("first pixel", 10, 0, 1, 5, 1);
    wait_idle("row1");
    check_reads("row1", 320, 320);

    tbl[0] = '{x: 10'd0,   y: 10'd1, b: 1, exp_pix: fb_pix(0, 1, 8'h00),   exp_v: 1};
    tbl[1] = '{x: 10'd639, y: 10'd3, b: 1, exp_pix: fb_pix(639, 3, 8'h00), exp_v: 1};
    tbl[2] = '{x: 10'd639, y: 10'd1, b: 1, exp_pix: fb_pix(639, 1, 8'h00), exp_v: 1};
    tbl[3] = '{x: 10'd0,   y: 10'd3, b: 0, exp_pix: 8'd0,                 exp_v: 0};
    for (int i = 4; i < 16; i++) begin
      x      = int'($urandom_range(639));
      tbl[i].x = 10'(x);
      tbl[i].y = ($urandom_range(1) == 1) ? 10'd3 : 10'd1;
      tbl[i].b = ($urandom_range(3) != 0);
      tbl[i].exp_pix = tbl[i].b ? fb_pix(x, int'(tbl[i].y), 8'h00) : 8'd0;
      tbl[i].exp_v   = tbl[i].b;
    end
    for (int i = 0; i < 16; i++)
      pix($sformatf("vec%0d", i), int'(tbl[i].x), int'(tbl[i].y), tbl[i].b,
          int'(tbl[i].exp_pix), int'(tbl[i].exp_v));
    chk("vectors no fetch", rd_addrs.size(), 0);

    // Row trigger DrawY 1->2: row 2 into bank 0
    draw_y = 10'd1;
    tick(2);
    draw_y = 10'd2;
    wait_idle("row2");
    check_reads("row2", 640, 320);
    x = int'($urandom_range(639));
    pix("row2 pixel", x, 5, 1, int'(fb_pix(x, 5, 8'h00)), 1);

    // Last row start does not trigger
    draw_y = 10'd477;
    tick(2);
    draw_y = 10'd478;
    tick(20);
    chk("row239 no fetch", int'(fetch_busy), 0);
    chk("row239 no read", rd_addrs.size(), 0);

    // Wait states: three extra cycles per acknowledge
    ack_waits = 3;
    salt      = 8'h5A;
    len_bad   = 0;
    stab_err  = 0;
    draw_y    = 10'd480;
    wait_idle("waitst");
    check_reads("waitst", 0, 320);
    chk("waitst address stable", stab_err, 0);
    chk("waitst read held 4 cycles", len_bad, 0);
    x = int'($urandom_range(639));
    pix("waitst pixel", x, 1, 1, int'(fb_pix(x, 1, 8'h5A)), 1);

    // Underrun: withheld acknowledge, new row trigger mid-fetch
    ack_waits = 1;
    salt      = 8'hC3;
    hold      = 1;
    len_check = 0;
    stab_err  = 0;
    draw_y    = 10'd2;
    tick(5);
    chk("held read", int'(br_read), 1);
    chk("held address", int'(br_addr), 640);
    chk("no underrun yet", int'(underrun), 0);
    draw_y = 10'd3;
    tick(1);
    draw_y = 10'd4;
    tick(3);
    chk("underrun set", int'(underrun), 1);
    chk("in-flight read held", int'(br_read), 1);
    chk("in-flight address held", int'(br_addr), 640);
    hold = 0;
    wait_idle("underrun");
    chk("underrun txn count", rd_addrs.size(), 321);
    if (rd_addrs.size() > 0) begin
      chk("in-flight address", int'(rd_addrs[0]), 640);
      void'(rd_addrs.pop_front());
    end
    check_reads("pending row3", 960, 320);
    chk("underrun address stable", stab_err, 0);
    chk("underrun sticky", int'(underrun), 1);
    pix("in-flight byte", 0, 5, 1, int'(data_of(640, 8'hC3)), 1);
    pix("abandoned col", 2, 5, 1, int'(data_of(1, 8'h5A)), 1);
    x = int'($urandom_range(639));
    pix("row3 pixel", x, 7, 1, int'(fb_pix(x, 7, 8'hC3)), 1);

    // Blanking masks valid buffer data
    pix("blanking", x, 7, 0, 0, 0);
    chk("underrun still sticky", int'(underrun), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_line_reader.md
# fb_line_reader

Read-side counterpart of the fractal framebuffer writer. Fetches 8-bit iteration values row by row from SDRAM over the external Avalon bridge into a ping-pong line buffer, one framebuffer row ahead of the raster, and presents the pixel for the current DrawX/DrawY to the VGA colour stage. Sits between the `jsv_sdram` bridge read port and the VGA pixel path, sharing the 50 MHz `CLK` with `vga_controller`.

## Interface
Parameters:
- `H_PIX`, 640: visible pixels per line.
- `V_PIX`, 480: visible lines per frame.
- `SCALE`, 2: screen pixels per framebuffer pixel, both axes. FB is `FW=H_PIX/SCALE` by `FH=V_PIX/SCALE`, i.e. 320x240 by default.
- `ADDR_W`, 19: bridge word-address width.
- `BASE_ADDR`, 0: word address of FB pixel (0,0).

Ports:
- `CLK` in 1: 50 MHz system clock, sole clock.
- `RESET` in 1: synchronous, active-low reset.
- `DrawX` in 10: current raster column from `vga_controller`.
- `DrawY` in 10: current raster line.
- `blank` in 1: 1 = visible region, 0 = blanking.
- `bridge_address` out ADDR_W: read word address.
- `bridge_read` out 1: read request, held until acknowledge.
- `bridge_byte_enable` out 4: constant 4'b0011.
- `bridge_acknowledge` in 1: transaction complete; read data valid this cycle.
- `bridge_read_data` in 16: bits [7:0] hold the iteration value.
- `PIX_I` out 8: iteration value for the raster position.
- `PIX_VALID` out 1: PIX_I is a visible pixel.
- `FETCH_BUSY` out 1: a row fetch is in progress.
- `UNDERRUN` out 1: sticky; a fetch trigger arrived before the previous fetch finished.

## Operation
- Layout: FB pixel (x,y) lives at `BASE_ADDR + y*FW + x`, low byte. Sum wraps mod 2^ADDR_W.
- Bank select: FB row r uses bank r[0]. Display row is `DrawY/SCALE`; display column is `DrawX/SCALE`.
- Triggers fire on the cycle DrawY changes value, registered-previous versus current:
  - New DrawY = k*SCALE, with k < FH-1: fetch row k+1 into bank (k+1)[0].
  - New DrawY = V_PIX: fetch row 0 into bank 0.
  - All other lines, including row FH-1 start: no trigger.
- FSM states IDLE, READ, NEXT:
  - IDLE: on trigger, latch row and set col=0. Go to READ.
  - READ: `bridge_read`=1 with address stable. On `bridge_acknowledge`, write `bridge_read_data[7:0]` to bank[col]. Go to NEXT.
  - NEXT: if col=FW-1, go to IDLE. Otherwise col++ and go to READ.
- `FETCH_BUSY` = state != IDLE.
- Trigger while busy:
  - Set UNDERRUN.
  - Latch the new row as pending.
  - The in-flight READ completes normally; a bus transaction is never aborted.
  - The next state is READ of the pending row at col 0, not NEXT.
  - The old fetch is abandoned.
- Trigger in IDLE in the same cycle as a busy-to-IDLE transition cannot occur; IDLE is entered from NEXT only.
- Pixel path: the RAM read address is combinational from DrawX/DrawY, and RAM output is registered. `PIX_VALID` is `blank` registered. `PIX_I` = RAM q when `PIX_VALID`, else 0.
- Width rules: col is 9 bits, holding 0..FW-1. Row is 8 bits. Address product computed at ADDR_W bits.

## Timing
- Reset, while RESET=0 at a CLK edge:
  - State IDLE, col 0, pending cleared.
  - `bridge_read`, `FETCH_BUSY`, `UNDERRUN`, `PIX_VALID` = 0; `PIX_I` = 0.
  - Previous-DrawY register loaded with the current DrawY, so no trigger fires on the first cycle after reset.
  - Line buffer contents are not cleared.
- Reset mid-fetch drops `bridge_read` on the next edge. This is acceptable because the bridge shares the reset.
- Pixel latency: 1 CLK from DrawX/DrawY/blank to `PIX_I`/`PIX_VALID`.
- Fetch throughput: at least 2 CLK per pixel (READ+NEXT) plus acknowledge wait. Budget is SCALE*1600 CLK per row for FW=320 pixels.
- Handshake: `bridge_address` and `bridge_read` are constant from READ entry until the acknowledge cycle inclusive. `bridge_read` is 0 in NEXT and IDLE.

## Structure
- Package `jsv_fb_pkg` holds:
  - the `fb_state_t` enum (IDLE/READ/NEXT);
  - `FB_BYTE_EN` = 4'b0011;
  - the FW/FH derivation functions, shared with the writer side.
- Sub-module `fb_line_ram`: simple dual-port, 2*FW x 8, one write port (fetch FSM) and one registered read port (pixel path). Infers block RAM.

## Test plan
- Reset: RESET=0 for 3 cycles with DrawY toggling -> `bridge_read`=0, `PIX_I`=0, `UNDERRUN`=0, no fetch starts on release.
- Frame prefetch:
  - DrawY 479->480, acknowledge 1 cycle after each read with data = col.
  - Expect 320 reads at addresses 0..319, `FETCH_BUSY` falling after col 319.
  - Then DrawY=0, DrawX=10, blank=1 -> `PIX_I`=5, `PIX_VALID`=1 one cycle later.
- Row trigger: DrawY 1->2 -> reads at addresses 640..959 into bank 0. DrawY 477->478 (row 239 start) -> no read.
- Wait states: acknowledge delayed 3 cycles -> `bridge_read`=1 and address constant for 4 cycles, one byte written.
- Underrun:
  - Withhold acknowledge; DrawY 3->4 mid-fetch -> `UNDERRUN`=1 and stays 1.
  - In-flight read completes on acknowledge, then the next read is at address 960 (row 3, col 0).
- Blanking: blank=0 with valid buffer data -> `PIX_I`=0, `PIX_VALID`=0 one cycle later.
